// File: rtl/load_align_unit.sv
// Load path between execute and word-wide data memory: issues an aligned word read,
// then extracts and sign/zero-extends the addressed byte, halfword or word.
module load_align_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        lb,
  input  logic        lbu,
  input  logic        lh,
  input  logic        lhu,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        load_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_r, next_s;
  size_t       size_r, dec_size_s;
  logic        sign_r, dec_sign_s;
  logic [1:0]  lane_r;
  logic [7:0]  cnt_r;
  logic [31:0] mem_addr_r;
  logic [31:0] load_data_r;
  logic        load_err_r;
  logic        misaligned_s;

  function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [1:0] lane,
                                          input size_t size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*lane +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: extract = {{24{sgn & b[7]}}, b};
      SZ_HALF: extract = {{16{sgn & h[15]}}, h};
      SZ_WORD: extract = rdata;
      default: extract = 32'h0000_0000;
    endcase
  endfunction

  // Decode load type (lb > lbu > lh > lhu > lw) and alignment of the incoming request
  always_comb begin
    dec_size_s = SZ_WORD;
    dec_sign_s = 1'b0;
    if (lb) begin
      dec_size_s = SZ_BYTE;
      dec_sign_s = 1'b1;
    end else if (lbu) begin
      dec_size_s = SZ_BYTE;
    end else if (lh) begin
      dec_size_s = SZ_HALF;
      dec_sign_s = 1'b1;
    end else if (lhu) begin
      dec_size_s = SZ_HALF;
    end else begin
      dec_size_s = SZ_WORD;
    end
    misaligned_s = ((dec_size_s == SZ_HALF) && req_addr[0]) ||
                   ((dec_size_s == SZ_WORD) && (req_addr[1:0] != 2'b00));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= next_s;
  end

  // Next-state logic; data beats the timeout when both occur in the same cycle
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) next_s = misaligned_s ? DONE : REQ;
        else           next_s = IDLE;
      end
      REQ:  next_s = WAIT;
      WAIT: begin
        if (mem_rvalid || (cnt_r == TIMEOUT_C)) next_s = DONE;
        else                                    next_s = WAIT;
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Request capture, wait counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_r      <= SZ_WORD;
      sign_r      <= 1'b0;
      lane_r      <= 2'b00;
      cnt_r       <= 8'd0;
      mem_addr_r  <= 32'h0000_0000;
      load_data_r <= 32'h0000_0000;
      load_err_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            size_r <= dec_size_s;
            sign_r <= dec_sign_s;
            lane_r <= req_addr[1:0];
            if (misaligned_s) begin
              load_data_r <= 32'h0000_0000;
              load_err_r  <= 1'b1;
            end else begin
              mem_addr_r <= {req_addr[31:2], 2'b00};
            end
          end
        end
        REQ: cnt_r <= 8'd0;
        WAIT: begin
          if (mem_rvalid) begin
            load_data_r <= extract(mem_rdata, lane_r, size_r, sign_r);
            load_err_r  <= 1'b0;
          end else if (cnt_r == TIMEOUT_C) begin
            load_data_r <= 32'h0000_0000;
            load_err_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_r == IDLE);
  assign mem_rd     = (state_r == REQ);
  assign load_valid = (state_r == DONE);
  assign mem_addr   = mem_addr_r;
  assign load_data  = load_data_r;
  assign load_err   = load_err_r;

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit with TIMEOUT=4; a scripted memory answers each read.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        lb = 1'b0, lbu = 1'b0, lh = 1'b0, lhu = 1'b0;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_rvalid = 1'b0;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_err;

  int compared = 0;
  int mismatched = 0;
  logic [32:0] sb_q[$];

  always #5 clk = ~clk;

  load_align_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .lb(lb), .lbu(lbu), .lh(lh), .lhu(lhu),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .load_valid(load_valid), .load_data(load_data), .load_err(load_err)
  );

  // typ = {lb,lbu,lh,lhu}; rv_delay = cycles after mem_rd that rvalid is driven (-1 = never)
  task automatic run_load(input string name, input logic [31:0] addr, input logic [3:0] typ,
                          input logic [31:0] rdata, input int rv_delay, input int exp_lat,
                          input int exp_rd, input logic [31:0] exp_data, input logic exp_err);
    int lat = -1;
    int rd_cnt = 0;
    logic [32:0] exp;
    logic [31:0] exp_maddr;
    @(negedge clk);
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s req_ready before accept: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_addr = addr; {lb, lbu, lh, lhu} = typ; mem_rdata = rdata;
    exp_maddr = {addr[31:2], 2'b00};
    sb_q.push_back({exp_err, exp_data});
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      req_valid = 1'b0; {lb, lbu, lh, lhu} = 4'b0000;
      if (mem_rd === 1'b1) begin
        rd_cnt++;
        compared++;
        if (mem_addr !== exp_maddr) begin
          mismatched++;
          $display("FAIL %s mem_addr: got %h want %h", name, mem_addr, exp_maddr);
        end
      end
      if (load_valid === 1'b1) begin
        lat = c;
        exp = sb_q.pop_front();
        compared++;
        if ({load_err, load_data} !== exp) begin
          mismatched++;
          $display("FAIL %s result: got err=%b data=%h want err=%b data=%h",
                   name, load_err, load_data, exp[32], exp[31:0]);
        end
        break;
      end
      mem_rvalid = (rv_delay >= 1) && (c == 1 + rv_delay);
    end
    mem_rvalid = 1'b0;
    compared++;
    if (lat != exp_lat) begin
      mismatched++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    compared++;
    if (rd_cnt != exp_rd) begin
      mismatched++;
      $display("FAIL %s mem_rd pulses: got %0d want %0d", name, rd_cnt, exp_rd);
    end
    @(negedge clk);
    compared++;
    if (req_ready !== 1'b1 || load_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL %s after done: got ready=%b valid=%b want ready=1 valid=0",
               name, req_ready, load_valid);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    compared++;
    if (req_ready !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 32'h0 || load_valid !== 1'b0 ||
        load_data !== 32'h0 || load_err !== 1'b0) begin
      mismatched++;
      $display("FAIL %s: got ready=%b rd=%b maddr=%h valid=%b data=%h err=%b want 1 0 0 0 0 0",
               name, req_ready, mem_rd, mem_addr, load_valid, load_data, load_err);
    end
  endtask

  task automatic test_reset();
    #1 check_idle_outputs("reset_during");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_after");
  endtask

  task automatic test_extract();
    run_load("lb_103",  32'h103, 4'b1000, 32'h80FF_1234, 2, 4, 1, 32'hFFFF_FF80, 1'b0);
    run_load("lhu_202", 32'h202, 4'b0001, 32'hFFFF_1111, 1, 3, 1, 32'h0000_FFFF, 1'b0);
    run_load("lh_202",  32'h202, 4'b0010, 32'hFFFF_1111, 1, 3, 1, 32'hFFFF_FFFF, 1'b0);
    run_load("lw_200",  32'h200, 4'b0000, 32'hFFFF_1111, 3, 5, 1, 32'hFFFF_1111, 1'b0);
    run_load("lb_001",  32'h001, 4'b1000, 32'h0000_AB00, 1, 3, 1, 32'hFFFF_FFAB, 1'b0);
    run_load("lh_000",  32'h000, 4'b0010, 32'h1234_7FFF, 1, 3, 1, 32'h0000_7FFF, 1'b0);
    run_load("lbu_102", 32'h102, 4'b0100, 32'h00C3_0000, 1, 3, 1, 32'h0000_00C3, 1'b0);
  endtask

  task automatic test_priority();
    run_load("prio_lb_lh",  32'h001, 4'b1010, 32'h0000_7F00, 1, 3, 1, 32'h0000_007F, 1'b0);
    run_load("prio_lbu_lh", 32'h003, 4'b0110, 32'h9A00_0000, 1, 3, 1, 32'h0000_009A, 1'b0);
    run_load("prio_lh_lhu", 32'h002, 4'b0011, 32'h8001_0000, 1, 3, 1, 32'hFFFF_8001, 1'b0);
  endtask

  task automatic test_misaligned();
    run_load("mis_lw_201",  32'h201, 4'b0000, 32'hDEAD_BEEF, 1, 1, 0, 32'h0, 1'b1);
    run_load("mis_lh_305",  32'h305, 4'b0010, 32'hDEAD_BEEF, 1, 1, 0, 32'h0, 1'b1);
    run_load("mis_lhu_003", 32'h003, 4'b0001, 32'hDEAD_BEEF, 1, 1, 0, 32'h0, 1'b1);
  endtask

  task automatic test_timeout();
    run_load("timeout",   32'h400, 4'b0000, 32'h5555_AAAA, -1, 7, 1, 32'h0, 1'b1);
    mem_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (load_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL late_rvalid cycle %0d: got valid=%b want 0", i, load_valid);
      end
    end
    mem_rvalid = 1'b0;
    run_load("wait4_data", 32'h404, 4'b0000, 32'h1357_9BDF, 4, 6, 1, 32'h1357_9BDF, 1'b0);
    run_load("edge_data",  32'h408, 4'b0000, 32'h2468_ACE0, 5, 7, 1, 32'h2468_ACE0, 1'b0);
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h200; {lb, lbu, lh, lhu} = 4'b0000;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 check_idle_outputs("rst_in_wait");
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      compared++;
      if (load_valid !== 1'b0 || mem_rd !== 1'b0) begin
        mismatched++;
        $display("FAIL rvalid_after_rst cycle %0d: got valid=%b rd=%b want 0 0",
                 i, load_valid, mem_rd);
      end
    end
    mem_rvalid = 1'b0;
    run_load("lbu_after_rst", 32'h001, 4'b0100, 32'h0000_AB00, 1, 3, 1, 32'h0000_00AB, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d;
      d = $urandom;
      run_load("b2b_lw", 32'h800 + 32'(4 * i), 4'b0000, d, 1, 3, 1, d, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_extract();
    test_priority();
    test_misaligned();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_empty: got %0d entries want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
